// File: rtl/lfsr_pkg.sv
// lfsr_pkg: shared definitions for the lfsr_stream generator.
//   - st_t: generator FSM encodings (IDLE / RUN / DRAIN)
//   - default feedback masks and seeds for common widths. Each mask sets
//     bit k for every term x^k of a primitive polynomial except x^WIDTH,
//     so feedback is fb = ^(state & TAPS) and the period is maximal.
package lfsr_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } st_t;

  // x^8 + x^4 + x^3 + x^2 + 1
  localparam logic [7:0]  TAPS8  = 8'h1D;
  localparam logic [7:0]  SEED8  = 8'h01;
  // x^16 + x^14 + x^13 + x^11 + 1
  localparam logic [15:0] TAPS16 = 16'h6801;
  localparam logic [15:0] SEED16 = 16'h0001;
  // x^32 + x^22 + x^2 + x + 1
  localparam logic [31:0] TAPS32 = 32'h0040_0007;
  localparam logic [31:0] SEED32 = 32'h0000_0001;

endpackage

// File: rtl/lfsr_stream_if.sv
// lfsr_stream_if: valid/ready output stream of the LFSR generator.
//   out_valid  producer -> consumer  out_data is valid
//   out_ready  consumer -> producer  consumer accepts out_data
//   out_data   producer -> consumer  current LFSR state (WIDTH bits)
// Modports: master (generator side), slave (consumer side).
interface lfsr_stream_if #(
  parameter int unsigned WIDTH = 8
);
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;

  modport master (output out_valid, output out_data, input out_ready);
  modport slave  (input out_valid, input out_data, output out_ready);
endinterface

// File: rtl/lfsr_step.sv
// lfsr_step: one combinational Fibonacci LFSR shift.
//   din   in   WIDTH  state before the shift
//   dout  out  WIDTH  {^(din & TAPS), din[WIDTH-1:1]}
module lfsr_step #(
  parameter int unsigned      WIDTH = 8,
  parameter logic [WIDTH-1:0] TAPS  = 8'h1D
) (
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);

  assign dout = {^(din & TAPS), din[WIDTH-1:1]};

endmodule

// File: rtl/lfsr_stream.sv
// lfsr_stream: clocked Fibonacci LFSR pseudo-random source with a
// valid/ready output stream, run-time seed load, STEP shifts per transfer,
// period-wrap pulse and zero-lock flag.
// Ports:
//   clk       in   clock, rising edge
//   rst_n     in   asynchronous reset, active-low
//   en        in   run request
//   ld_valid  in   seed load strobe (one cycle)
//   ld_data   in   seed value (WIDTH bits)
//   strm      lfsr_stream_if.master: out_valid / out_ready / out_data
//   wrap      out  one-cycle pulse after a transfer lands on the loaded seed
//   locked    out  state is all-zero
// Configuration macro: LFSR_ZERO_GUARD_EN
//   defined   -> a zero load is replaced by SEED, locked tied to 0
//   undefined -> a zero load is accepted, locked flags the stuck state
module lfsr_stream
  import lfsr_pkg::*;
#(
  parameter int unsigned      WIDTH = 8,
  parameter logic [WIDTH-1:0] TAPS  = WIDTH'(TAPS8),
  parameter logic [WIDTH-1:0] SEED  = WIDTH'(SEED8),
  parameter int unsigned      STEP  = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             ld_valid,
  input  logic [WIDTH-1:0] ld_data,
  lfsr_stream_if.master    strm,
  output logic             wrap,
  output logic             locked
);

  st_t              st, st_nxt;
  logic [WIDTH-1:0] state, state_nxt, seed_reg, shifted, ld_val;
  logic             valid, xfer;
  logic [WIDTH-1:0] chain [STEP+1];

  // STEP chained single shifts; chain[STEP] is the post-transfer state
  assign chain[0] = state;
  for (genvar i = 0; i < STEP; i++) begin : g_step
    lfsr_step #(.WIDTH(WIDTH), .TAPS(TAPS)) u_step (
      .din  (chain[i]),
      .dout (chain[i+1])
    );
  end
  assign shifted = chain[STEP];

`ifdef LFSR_ZERO_GUARD_EN
  assign ld_val = (ld_data == '0) ? SEED : ld_data;
`else
  assign ld_val = ld_data;
`endif

  // out_valid is decoded from the state register only, so no input
  // reaches the stream outputs combinationally
  assign valid          = (st != ST_IDLE);
  assign xfer           = valid & strm.out_ready;
  assign strm.out_valid = valid;
  assign strm.out_data  = state;

  always_comb begin
    st_nxt = st;
    unique case (st)
      ST_IDLE:  if (en) st_nxt = ST_RUN;
      ST_RUN:   if (!en) st_nxt = xfer ? ST_IDLE : ST_DRAIN;
      ST_DRAIN: if (xfer) st_nxt = ST_IDLE;
      default:  st_nxt = ST_IDLE;
    endcase
  end

  // A load overrides the shift of a coincident transfer
  always_comb begin
    state_nxt = state;
    if (ld_valid)  state_nxt = ld_val;
    else if (xfer) state_nxt = shifted;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st       <= ST_IDLE;
      state    <= SEED;
      seed_reg <= SEED;
      wrap     <= 1'b0;
    end else begin
      st    <= st_nxt;
      state <= state_nxt;
      if (ld_valid) seed_reg <= ld_val;
      wrap <= xfer & ~ld_valid & (shifted == seed_reg);
    end
  end

`ifdef LFSR_ZERO_GUARD_EN
  assign locked = 1'b0;
`else
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) locked <= 1'b0;
    else        locked <= (state_nxt == '0);
  end
`endif

endmodule

// File: tb/tb_lfsr_stream.sv
module tb_lfsr_stream;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       en = 1'b0;
  logic       ld_valid = 1'b0;
  logic [7:0] ld_data = '0;
  logic       wrap, locked;
  logic       ld4_valid = 1'b0;
  logic [7:0] ld4_data = '0;
  logic       wrap4, locked4;

  int unsigned checks = 0;
  int unsigned failures = 0;

  lfsr_stream_if #(.WIDTH(8)) sif ();
  lfsr_stream_if #(.WIDTH(8)) sif4 ();

  lfsr_stream #(.WIDTH(8), .TAPS(8'h1D), .SEED(8'h01), .STEP(1)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .ld_valid(ld_valid), .ld_data(ld_data),
    .strm(sif), .wrap(wrap), .locked(locked)
  );

  lfsr_stream #(.WIDTH(8), .TAPS(8'h1D), .SEED(8'h01), .STEP(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .en(en), .ld_valid(ld4_valid), .ld_data(ld4_data),
    .strm(sif4), .wrap(wrap4), .locked(locked4)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] nxt(input logic [7:0] s);
    return {^(s & 8'h1D), s[7:1]};
  endfunction

  logic [7:0] hand [9];
  logic [7:0] hand4 [3];
  logic [7:0] model;

  initial begin
    hand[0] = 8'h01; hand[1] = 8'h80; hand[2] = 8'h40; hand[3] = 8'h20; hand[4] = 8'h10;
    hand[5] = 8'h88; hand[6] = 8'hC4; hand[7] = 8'hE2; hand[8] = 8'h71;
    hand4[0] = 8'h01; hand4[1] = 8'h10; hand4[2] = 8'h71;
    sif.out_ready  = 1'b1;
    sif4.out_ready = 1'b1;

    // reset state
    repeat (2) @(negedge clk);
    chk("rst_valid", 32'(sif.out_valid), 32'd0);
    chk("rst_data", 32'(sif.out_data), 32'h01);
    chk("rst_wrap", 32'(wrap), 32'd0);
    chk("rst_locked", 32'(locked), 32'd0);
    en = 1'b1;
    rst_n = 1'b1;

    // free run: one word per cycle, wrap only after transfer 255
    model = 8'h01;
    for (int i = 0; i < 260; i++) begin
      @(negedge clk);
      chk("run_valid", 32'(sif.out_valid), 32'd1);
      chk("run_data", 32'(sif.out_data), 32'(model));
      chk("run_wrap", 32'(wrap), (i == 255) ? 32'd1 : 32'd0);
      if (i < 9) chk("hand_data", 32'(sif.out_data), 32'(hand[i]));
      if (i < 3) chk("step4_data", 32'(sif4.out_data), 32'(hand4[i]));
      if (i == 255) chk("wrap_state", 32'(sif.out_data), 32'h01);
      model = nxt(model);
    end

    // back-pressure then drain
    @(negedge clk);
    sif.out_ready = 1'b0;
    chk("bp_first", 32'(sif.out_data), 32'(model));
    repeat (5) begin
      @(negedge clk);
      chk("bp_valid", 32'(sif.out_valid), 32'd1);
      chk("bp_data", 32'(sif.out_data), 32'(model));
    end
    en = 1'b0;
    @(negedge clk);
    chk("drain_valid", 32'(sif.out_valid), 32'd1);
    chk("drain_data", 32'(sif.out_data), 32'(model));
    // en is ignored in DRAIN: the transfer must still lead to IDLE
    en = 1'b1;
    sif.out_ready = 1'b1;
    @(negedge clk);
    model = nxt(model);
    chk("drain_idle_valid", 32'(sif.out_valid), 32'd0);
    chk("drain_idle_data", 32'(sif.out_data), 32'(model));
    en = 1'b0;
    @(negedge clk);
    chk("idle_hold_valid", 32'(sif.out_valid), 32'd0);
    chk("idle_hold_data", 32'(sif.out_data), 32'(model));

    // load coincident with a transfer: load wins, no shift, no wrap
    en = 1'b1;
    @(negedge clk);
    chk("ld_pre_valid", 32'(sif.out_valid), 32'd1);
    chk("ld_pre_data", 32'(sif.out_data), 32'(model));
    ld_valid = 1'b1;
    ld_data  = 8'h5A;
    @(negedge clk);
    ld_valid = 1'b0;
    chk("ld_data", 32'(sif.out_data), 32'h5A);
    chk("ld_valid", 32'(sif.out_valid), 32'd1);
    chk("ld_wrap", 32'(wrap), 32'd0);
    @(negedge clk);
    chk("ld_next", 32'(sif.out_data), 32'(nxt(8'h5A)));

    // zero load
    ld_valid = 1'b1;
    ld_data  = 8'h00;
    @(negedge clk);
    ld_valid = 1'b0;
`ifdef LFSR_ZERO_GUARD_EN
    chk("zero_data", 32'(sif.out_data), 32'h01);
    chk("zero_locked", 32'(locked), 32'd0);
    @(negedge clk);
    chk("zero_next", 32'(sif.out_data), 32'h80);
    chk("zero_locked2", 32'(locked), 32'd0);
`else
    chk("zero_data", 32'(sif.out_data), 32'h00);
    chk("zero_locked", 32'(locked), 32'd1);
    @(negedge clk);
    chk("zero_next", 32'(sif.out_data), 32'h00);
    chk("zero_locked2", 32'(locked), 32'd1);
    chk("zero_valid", 32'(sif.out_valid), 32'd1);
`endif
    ld_valid = 1'b1;
    ld_data  = 8'h01;
    @(negedge clk);
    ld_valid = 1'b0;
    chk("unlock_data", 32'(sif.out_data), 32'h01);
    chk("unlock_locked", 32'(locked), 32'd0);

    // asynchronous reset mid-run
    #2 rst_n = 1'b0;
    #1;
    chk("arst_valid", 32'(sif.out_valid), 32'd0);
    chk("arst_data", 32'(sif.out_data), 32'h01);
    chk("arst_wrap", 32'(wrap), 32'd0);
    chk("arst_locked", 32'(locked), 32'd0);
    chk("arst_step4", 32'(sif4.out_data), 32'h01);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
